// File: rtl/key_pkg.sv
// key_pkg: shared FSM state type and counter sizing helper for key_pulse_array
package key_pkg;

   typedef enum logic [1:0] {K_IDLE, K_HELD, K_REPEAT} key_state_t;

   function automatic int cnt_w(input int x);
      return (x < 1) ? 1 : $clog2(x + 1);
   endfunction

endpackage

// File: rtl/key_channel.sv
// key_channel: synchronise, normalise, debounce and pulse-encode one push-button
module key_channel
   import key_pkg::*;
#(
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 64,
   parameter int REPEAT_RATE     = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_raw_i,
   input  logic repeat_en_i,
   output logic press_o,
   output logic release_o,
   output logic held_o
);

   localparam int DW   = cnt_w(DEBOUNCE_CYCLES);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = cnt_w(RMAX);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);

   logic [1:0]    sync_q;
   logic          level;
   logic          deb_q, deb_d;
   logic [DW-1:0] db_cnt_q, db_cnt_d;
   key_state_t    state_q, state_d;
   logic [RW-1:0] rep_cnt_q, rep_cnt_d;
   logic          press_q, press_d, release_q, release_d, held_q, held_d;

   // two-flop synchroniser, cleared to the released pin level
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) sync_q <= {2{ACTIVE_LOW}};
      else sync_q <= {sync_q[0], key_raw_i};

   assign level = sync_q[1] ^ ACTIVE_LOW;

   // debounced level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample
   always_comb begin
      deb_d    = deb_q;
      db_cnt_d = '0;
      if (level != deb_q) begin
         if (db_cnt_q >= DB_LAST) deb_d = level;
         else db_cnt_d = db_cnt_q + 1'b1;
      end
   end

   // press/release/repeat decisions on the debounced level; release wins over a due repeat
   always_comb begin
      state_d   = state_q;
      rep_cnt_d = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      held_d    = deb_q;
      case (state_q)
         K_IDLE: begin
            state_d = deb_q ? K_HELD : K_IDLE;
            press_d = deb_q;
         end
         K_HELD, K_REPEAT: begin
            if (!deb_q) begin
               state_d   = K_IDLE;
               release_d = 1'b1;
            end else if (!repeat_en_i) begin
               state_d = K_HELD;
            end else if (rep_cnt_q >= ((state_q == K_REPEAT) ? RR_LAST : RD_LAST)) begin
               state_d = K_REPEAT;
               press_d = 1'b1;
            end else begin
               rep_cnt_d = rep_cnt_q + 1'b1;
            end
         end
         default: state_d = K_IDLE;
      endcase
   end

   // state, counters and registered outputs
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         deb_q     <= 1'b0;
         db_cnt_q  <= '0;
         state_q   <= K_IDLE;
         rep_cnt_q <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         deb_q     <= deb_d;
         db_cnt_q  <= db_cnt_d;
         state_q   <= state_d;
         rep_cnt_q <= rep_cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
         held_q    <= held_d;
      end

   assign press_o   = press_q;
   assign release_o = release_q;
   assign held_o    = held_q;

endmodule

// File: rtl/key_pulse_array.sv
// key_pulse_array: N independent debounced push-button channels with press/release/repeat pulses
module key_pulse_array
   import key_pkg::*;
#(
   parameter int N_KEYS          = 4,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 64,
   parameter int REPEAT_RATE     = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [N_KEYS-1:0] keys_raw,
   input  logic [N_KEYS-1:0] repeat_en,
   output logic [N_KEYS-1:0] press_pulse,
   output logic [N_KEYS-1:0] release_pulse,
   output logic [N_KEYS-1:0] held
);

   if (N_KEYS < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
      $fatal(1, "key_pulse_array: N_KEYS and all timing parameters must be >= 1");
   end

   for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      key_channel #(
         .ACTIVE_LOW      (ACTIVE_LOW),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_RATE     (REPEAT_RATE)
      ) u_ch (
         .clk         (clk),
         .reset_n     (reset_n),
         .key_raw_i   (keys_raw[i]),
         .repeat_en_i (repeat_en[i]),
         .press_o     (press_pulse[i]),
         .release_o   (release_pulse[i]),
         .held_o      (held[i])
      );
   end

endmodule

// File: tb/tb_key_pulse_array.sv
// tb_key_pulse_array: scoreboard bench with a window-based behavioural model of key_pulse_array
module tb_key_pulse_array;

   localparam int N  = 4;
   localparam int DC = 4;
   localparam int RD = 10;
   localparam int RR = 3;

   typedef struct packed {
      logic [N-1:0] p;
      logic [N-1:0] r;
      logic [N-1:0] h;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [N-1:0] keys_raw = '1;
   logic [N-1:0] repeat_en = '0;
   logic [N-1:0] press_pulse, release_pulse, held;

   exp_t exp_q[$];
   int   checks = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   key_pulse_array #(
      .N_KEYS (N), .ACTIVE_LOW (1'b1), .DEBOUNCE_CYCLES (DC),
      .REPEAT_DELAY (RD), .REPEAT_RATE (RR)
   ) dut (
      .clk (clk), .reset_n (reset_n), .keys_raw (keys_raw), .repeat_en (repeat_en),
      .press_pulse (press_pulse), .release_pulse (release_pulse), .held (held)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
   endtask

   // reference model: pressed history per channel; the debounced level flips when the
   // DC samples that reached the debouncer (two edges of synchroniser delay) all disagree
   // with it; outputs follow one edge later; repeats count consecutive enabled edges
   logic [31:0] hist[N];
   bit          mdeb[N], mheld[N], fired[N];
   int          run[N];

   initial forever begin
      exp_t e;
      bit   d, flip;
      @(posedge clk);
      e = '0;
      if (!reset_n) begin
         for (int c = 0; c < N; c++) begin
            hist[c] = '0; mdeb[c] = 0; mheld[c] = 0; fired[c] = 0; run[c] = 0;
         end
      end else begin
         for (int c = 0; c < N; c++) begin
            d = mdeb[c];
            hist[c] = {hist[c][30:0], ~keys_raw[c]};
            if (d && !mheld[c]) begin
               e.p[c] = 1'b1; run[c] = 0; fired[c] = 0;
            end else if (!d && mheld[c]) begin
               e.r[c] = 1'b1; run[c] = 0;
            end else if (mheld[c]) begin
               if (!repeat_en[c]) begin
                  run[c] = 0; fired[c] = 0;
               end else begin
                  run[c]++;
                  if (run[c] == (fired[c] ? RR : RD)) begin
                     e.p[c] = 1'b1; run[c] = 0; fired[c] = 1;
                  end
               end
            end
            mheld[c] = d;
            e.h[c] = d;
            flip = 1;
            for (int k = 2; k <= DC + 1; k++) if (hist[c][k] == d) flip = 0;
            if (flip) mdeb[c] = !d;
         end
      end
      exp_q.push_back(e);
   end

   // monitor: outputs are presented every cycle; compare away from the active edge
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("press_pulse", 32'(press_pulse), 32'(e.p));
         chk("release_pulse", 32'(release_pulse), 32'(e.r));
         chk("held", 32'(held), 32'(e.h));
         chk("press_and_release_overlap", 32'(press_pulse & release_pulse), 32'd0);
      end
   end

   // count negedges until the chosen pulse appears on channel ch (bounded)
   task automatic expect_pulse(input int ch, input bit rel, input int want, input string name);
      int n = 0;
      bit seen = 0;
      while (n < 40 && !seen) begin
         @(negedge clk);
         n++;
         seen = rel ? release_pulse[ch] : press_pulse[ch];
      end
      chk(name, 32'(n), 32'(want));
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      wait_cycles(3);
      reset_n = 1'b1;
      // idle with all keys released
      wait_cycles(20);
      // clean press/release on key 0
      keys_raw[0] = 1'b0;
      expect_pulse(0, 0, DC + 3, "press_latency_k0");
      chk("held_k0_on_press", 32'(held[0]), 32'd1);
      wait_cycles(13);
      keys_raw[0] = 1'b1;
      expect_pulse(0, 1, DC + 3, "release_latency_k0");
      chk("held_k0_on_release", 32'(held[0]), 32'd0);
      wait_cycles(5);
      // bouncing key 1, glitches shorter than the debounce window
      for (int i = 0; i < 6; i++) begin
         keys_raw[1] = i[0];
         wait_cycles(2);
      end
      keys_raw[1] = 1'b1;
      wait_cycles(10);
      // auto-repeat on key 2
      repeat_en[2] = 1'b1;
      keys_raw[2] = 1'b0;
      expect_pulse(2, 0, DC + 3, "press_latency_k2");
      expect_pulse(2, 0, RD, "first_repeat_k2");
      expect_pulse(2, 0, RR, "second_repeat_k2");
      // repeat disabled mid-hold
      repeat_en[2] = 1'b0;
      wait_cycles(15);
      chk("held_k2_repeat_off", 32'(held[2]), 32'd1);
      repeat_en[2] = 1'b1;
      expect_pulse(2, 0, RD, "reenable_repeat_k2");
      // release timed to land on a due repeat: only the release may fire
      wait_cycles(2);
      keys_raw[2] = 1'b1;
      expect_pulse(2, 1, DC + 3, "release_latency_k2");
      chk("no_press_on_release_k2", 32'(press_pulse[2]), 32'd0);
      repeat_en[2] = 1'b0;
      wait_cycles(5);
      // simultaneous keys 0 and 3
      keys_raw[0] = 1'b0;
      keys_raw[3] = 1'b0;
      expect_pulse(0, 0, DC + 3, "press_latency_k0_sim");
      chk("simultaneous_press", 32'(press_pulse & 4'b1001), 32'h9);
      wait_cycles(4);
      // asynchronous reset between edges while held
      #1 reset_n = 1'b0;
      #1 chk("async_reset_held", 32'(held), 32'd0);
      chk("async_reset_press", 32'(press_pulse), 32'd0);
      chk("async_reset_release", 32'(release_pulse), 32'd0);
      wait_cycles(3);
      reset_n = 1'b1;
      expect_pulse(0, 0, DC + 3, "press_after_reset_k0");
      chk("press_after_reset_k3", 32'(press_pulse[3]), 32'd1);
      wait_cycles(3);
      keys_raw = '1;
      wait_cycles(12);
      // randomised presses, glitches and repeat toggling
      for (int t = 0; t < 600; t++) begin
         for (int c = 0; c < N; c++) begin
            if ($urandom_range(0, 9) == 0) keys_raw[c] = ~keys_raw[c];
            if ($urandom_range(0, 29) == 0) repeat_en[c] = ~repeat_en[c];
         end
         wait_cycles(1);
      end
      keys_raw = '1;
      wait_cycles(15);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/key_pulse_array.md
Name: key_pulse_array

Overview:
Parametrised N-channel push-button conditioner that replaces single-key one-shot logic across the lab designs. For each channel it synchronises the raw key, normalises polarity, debounces, and emits one-cycle press and release pulses. An optional auto-repeat mode re-fires the press pulse while a key is held. It sits between the board KEY/SW pins and every FSM that consumes user commands.

Parameters:
N_KEYS, 4, number of independent key channels
ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed (DE1 KEYs); 0 = reads 1 when pressed
DEBOUNCE_CYCLES, 16, consecutive stable cycles required before the debounced level changes (>=1)
REPEAT_DELAY, 64, cycles from the initial press pulse to the first repeat pulse (>=1)
REPEAT_RATE, 16, cycles between subsequent repeat pulses (>=1)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
keys_raw  input  N_KEYS  raw asynchronous key pins
repeat_en  input  N_KEYS  per-channel auto-repeat enable; sampled every cycle
press_pulse  output  N_KEYS  one-cycle pulse on debounced press, and on each auto-repeat
release_pulse  output  N_KEYS  one-cycle pulse on debounced release
held  output  N_KEYS  debounced pressed level

Behaviour:
- Reset (reset_n=0, async): all outputs 0, synchronisers cleared to "released", debounce and repeat counters 0, every FSM in K_IDLE. A key held through reset is reported as a new press after reset_n rises, with full latency.
- Per channel: 2-flop synchroniser -> polarity normalise (pressed=1) -> debounce -> FSM. Channels are fully independent, and simultaneous events on different channels are each reported in the same cycle.
- Debounce: the counter increments while the synchronised level differs from the debounced level and clears whenever they agree. The debounced level flips when the level has differed for DEBOUNCE_CYCLES consecutive cycles. Glitches shorter than DEBOUNCE_CYCLES produce no output.
- Latency: E0 is the first clock edge at which the new raw level is sampled. With the level held stable, the pulse and the held change are high or low in the cycle following edge E0+DEBOUNCE_CYCLES+2.
- All outputs are registered.
- FSM states: K_IDLE, K_HELD, K_REPEAT.
  - K_IDLE -> K_HELD on debounced press. press_pulse=1 for one cycle; held=1.
  - K_HELD: the repeat counter counts while repeat_en=1. When it reaches REPEAT_DELAY: press_pulse=1 for one cycle, counter clears, move to K_REPEAT.
  - K_REPEAT: press_pulse=1 for one cycle every REPEAT_RATE cycles.
  - In K_HELD or K_REPEAT, if repeat_en=0: repeat counter clears, state goes to (or stays in) K_HELD, and no repeat pulses fire. Re-enabling repeat restarts the full REPEAT_DELAY.
  - K_HELD or K_REPEAT -> K_IDLE on debounced release. release_pulse=1 for one cycle; held=0; repeat counter clears. Release takes priority over a repeat pulse due in the same cycle.
- press_pulse and release_pulse are never high together on one channel.
- Counter widths: $clog2(X+1) of the respective parameter. Counters saturate and never wrap.
- Illegal parameters (any timing parameter = 0, N_KEYS = 0) are rejected by elaboration-time assertions.

Decomposition:
- Package key_pkg: typedef enum key_state_t {K_IDLE, K_HELD, K_REPEAT}; localparam width helper function for counter sizing.
- Sub-module key_channel: synchroniser, debounce and FSM for one channel, parameterised identically.
- key_pulse_array: generate loop of N_KEYS key_channel instances, plus the parameter assertions.

Test Plan:
All scenarios use N_KEYS=4, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
1. Reset then idle: keys_raw=4'hF for 20 cycles -> all outputs 0 throughout.
2. Clean press/release: keys_raw[0]=0 from edge E0, held 20 cycles, then 1.
   - press_pulse[0] high exactly one cycle after E0+6; held[0]=1 from the same cycle.
   - release_pulse[0] one cycle after release E+6; held[0]=0.
3. Bounce: keys_raw[1] toggles 0/1 every 2 cycles for 12 cycles, then stays 1 -> no pulses, held[1]=0 throughout.
4. Auto-repeat: repeat_en[2]=1, key 2 held 30 cycles.
   - press_pulse[2] at cycles p, p+10, p+13, p+16, ...
   - Release during a due repeat cycle yields only release_pulse[2].
5. Repeat disable mid-hold: drop repeat_en[2] after the p+13 pulse -> no further press pulses; held stays 1. Re-enable -> next pulse 10 cycles later.
6. Simultaneous and reset:
   - Keys 0 and 3 pressed on the same edge -> both pulses in the same cycle.
   - reset_n=0 asserted mid-hold (async, between edges) -> outputs 0 immediately.
   - Key still held at reset_n rise -> new press pulse after 6+1 cycles.
